// File: rtl/des_key_scheduler.sv
// ============================================================================
// des_key_scheduler
//
// Generates the sixteen DES round subkeys from one 64-bit key and hands them
// to the round datapath one per handshake. PC-1 is applied once when a
// schedule starts. The C/D halves then live in two 28-bit registers that are
// rotated between subkeys. Decrypt order runs the rotations backwards
// (right rotations starting from C16 = C0), so no subkey storage is needed.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start        request a new schedule (only looked at in IDLE)
//   decrypt      sampled with start: 0 = K1..K16, 1 = K16..K1
//   key_in       64-bit key, bit 63 = DES bit 1 (parity bits unused)
//   subkey_ready consumer accepts the presented subkey
//   subkey       PC-2(C,D) of the current registers, bit 47 = DES bit 1
//   subkey_valid subkey is being presented
//   round_idx    position of the presented subkey in emission order, 0..15
//   busy         schedule in progress
//   done         one-cycle pulse after the 16th subkey is accepted
//
// Handshake: a subkey transfers on a rising edge where subkey_valid and
// subkey_ready are both high. While subkey_valid is high and subkey_ready is
// low, subkey and round_idx hold steady. subkey_valid never drops until the
// transfer happens, except on reset. subkey_ready may change freely.
// ============================================================================
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    // DES bit numbers (1 = MSB) selected for each output position.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Kept as a named, typed register so checkers can bind to it directly.
    state_t      state;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic        mode;       // 1 = decrypt order

    logic [55:0] cd0;
    logic [4:0]  shift_round;
    logic        two;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47 - i] = cd[56 - PC2[i]];
        end
        return r;
    endfunction

    // Shift schedule: rounds 1, 2, 9 and 16 rotate by one, all others by two.
    function automatic logic shift_is_two(input logic [4:0] n);
        return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by_two);
        return by_two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by_two);
        return by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign cd0 = pc1(key_in);

    // Round number (1-based) whose shift produces the next subkey.
    // Encrypt: after emitting K(r+1) move on to K(r+2) with its own shift.
    // Decrypt: after emitting K(16-r) undo the shift that produced it.
    assign shift_round = mode ? (5'd16 - {1'b0, round_idx})
                              : ({1'b0, round_idx} + 5'd2);
    assign two = shift_is_two(shift_round);

    assign subkey = pc2({c_q, d_q});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            c_q          <= '0;
            d_q          <= '0;
            mode         <= 1'b0;
            round_idx    <= 4'd0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode <= decrypt;
                        if (decrypt) begin
                            // C16/D16 equal C0/D0 since the rotations sum to 28.
                            c_q <= cd0[55:28];
                            d_q <= cd0[27:0];
                        end else begin
                            c_q <= rotl28(cd0[55:28], 1'b0);
                            d_q <= rotl28(cd0[27:0], 1'b0);
                        end
                        round_idx    <= 4'd0;
                        subkey_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (subkey_ready) begin
                        if (round_idx == 4'd15) begin
                            subkey_valid <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            round_idx <= round_idx + 4'd1;
                            if (mode) begin
                                c_q <= rotr28(c_q, two);
                                d_q <= rotr28(d_q, two);
                            end else begin
                                c_q <= rotl28(c_q, two);
                                d_q <= rotl28(d_q, two);
                            end
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    subkey_valid <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// ============================================================================
// tb_des_key_scheduler
//
// Directed bench for des_key_scheduler. Expected {round_idx, subkey} pairs
// are queued when a schedule is started. A monitor pops one entry on every
// handshake and compares it. The monitor also checks that subkey and
// round_idx hold steady across stalled cycles.
// ============================================================================
module tb_des_key_scheduler;

    localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
    localparam logic [63:0] PARITY = 64'h0101010101010101;
    localparam logic [63:0] OTHER  = 64'h0123456789ABCDEF;
    localparam logic [63:0] OTHER2 = 64'hFEDCBA9876543210;

    // Known DES subkeys K1..K16 for KEY.
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [51:0] exp_q [$];

    des_key_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic        stall_pend = 1'b0;
    logic [51:0] held;

    always @(negedge clk) begin
        logic [51:0] e;
        if (rst_n) begin
            if (stall_pend && subkey_valid)
                check("stall_hold", {12'd0, round_idx, subkey}, {12'd0, held});
            if (subkey_valid && subkey_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_subkey: got idx %0d key %h with empty queue",
                             round_idx, subkey);
                end else begin
                    e = exp_q.pop_front();
                    check("subkey", {12'd0, round_idx, subkey}, {12'd0, e});
                end
            end
            stall_pend = subkey_valid && !subkey_ready;
            held       = {round_idx, subkey};
            if (done) done_cnt++;
        end else begin
            stall_pend = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_seq(input bit dec);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] idx;
            idx = 4'(i);
            exp_q.push_back({idx, dec ? KS[15 - i] : KS[i]});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle later.
    task automatic drive_start(input logic [63:0] k, input logic dec);
        start   = 1'b1;
        key_in  = k;
        decrypt = dec;
        @(posedge clk); #1;
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
    endtask

    // Cycle 1 is the first cycle after the start cycle. rdy_mode 1 randomises
    // subkey_ready and stalls 5 cycles at round_idx 3. inject_c pulses start
    // with a foreign key in that cycle. rogue_done pulses start during DONE.
    task automatic wait_sched(input int rdy_mode, input int inject_c, input bit rogue_done,
                              output int first_valid, output int nvalid,
                              output int done_cyc, output int busy_bad);
        int stall_left;
        stall_left  = 5;
        first_valid = -1;
        nvalid      = 0;
        done_cyc    = -1;
        busy_bad    = 0;
        for (int c = 1; c <= 400; c++) begin
            start = (c == inject_c);
            if (c == inject_c) begin
                key_in  = OTHER;
                decrypt = 1'b1;
            end
            if (rdy_mode == 1) begin
                if (subkey_valid && round_idx == 4'd3 && stall_left > 0) begin
                    subkey_ready = 1'b0;
                    stall_left--;
                end else begin
                    subkey_ready = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            if (subkey_valid) begin
                nvalid++;
                if (first_valid < 0) first_valid = c;
            end
            if (busy !== subkey_valid) busy_bad++;
            if (done) begin
                done_cyc = c;
                if (rogue_done) begin
                    start   = 1'b1;
                    key_in  = OTHER2;
                    decrypt = 1'b0;
                end
                @(posedge clk); #1;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int fv, nv, dc, bb, d0;

        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'd0, subkey_valid}, 64'd0);
        check("rst_busy",  {63'd0, busy},         64'd0);
        check("rst_done",  {63'd0, done},         64'd0);
        check("rst_idx",   {60'd0, round_idx},    64'd0);
        check("rst_subkey", {16'd0, subkey},      64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encrypt, ready tied high: valid cycles 1..16, done at 17.
        subkey_ready = 1'b1;
        push_seq(1'b0);
        drive_start(KEY, 1'b0);
        wait_sched(0, 0, 1'b0, fv, nv, dc, bb);
        check("enc_first_valid", 64'(fv), 64'd1);
        check("enc_nvalid",      64'(nv), 64'd16);
        check("enc_done_cycle",  64'(dc), 64'd17);
        check("enc_busy",        64'(bb), 64'd0);
        check("enc_queue_empty", 64'(exp_q.size()), 64'd0);

        // Decrypt started in the very next cycle (cycle 18 of the last run).
        push_seq(1'b1);
        drive_start(KEY, 1'b1);
        wait_sched(0, 0, 1'b0, fv, nv, dc, bb);
        check("dec_first_valid", 64'(fv), 64'd1);
        check("dec_done_cycle",  64'(dc), 64'd17);
        check("dec_queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_count_2",    64'(done_cnt), 64'd2);

        // Backpressure with random ready and a 5-cycle stall at round 3.
        d0 = done_cnt;
        push_seq(1'b0);
        drive_start(KEY, 1'b0);
        wait_sched(1, 0, 1'b0, fv, nv, dc, bb);
        check("bp_done_seen",   64'(dc > 0), 64'd1);
        check("bp_min_valid",   64'(nv >= 21), 64'd1);
        check("bp_busy",        64'(bb), 64'd0);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("bp_done_once",   64'(done_cnt - d0), 64'd1);

        // start during EMIT and during DONE is ignored. The start in the
        // following IDLE cycle is taken.
        subkey_ready = 1'b1;
        @(posedge clk); #1;
        push_seq(1'b0);
        drive_start(KEY, 1'b0);
        wait_sched(0, 5, 1'b1, fv, nv, dc, bb);
        check("ign_done_cycle",  64'(dc), 64'd17);
        check("ign_queue_empty", 64'(exp_q.size()), 64'd0);
        push_seq(1'b1);
        drive_start(KEY, 1'b1);
        wait_sched(0, 0, 1'b0, fv, nv, dc, bb);
        check("idle_start_first", 64'(fv), 64'd1);
        check("idle_start_queue", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a schedule at round_idx 7.
        push_seq(1'b0);
        drive_start(KEY, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (round_idx == 4'd7) break;
            @(posedge clk); #1;
        end
        check("mid_idx_reached", {60'd0, round_idx}, 64'd7);
        rst_n        = 1'b0;
        subkey_ready = 1'b0;
        d0           = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_valid", {63'd0, subkey_valid}, 64'd0);
        check("abort_busy",  {63'd0, busy},         64'd0);
        check("abort_done",  {63'd0, done},         64'd0);
        check("abort_idx",   {60'd0, round_idx},    64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        subkey_ready = 1'b1;
        push_seq(1'b0);
        drive_start(KEY, 1'b0);
        wait_sched(0, 0, 1'b0, fv, nv, dc, bb);
        check("post_abort_done",  64'(dc), 64'd17);
        check("post_abort_queue", 64'(exp_q.size()), 64'd0);

        // Parity bits flipped: same schedule.
        push_seq(1'b0);
        drive_start(KEY ^ PARITY, 1'b0);
        wait_sched(0, 0, 1'b0, fv, nv, dc, bb);
        check("parity_done",  64'(dc), 64'd17);
        check("parity_queue", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
